// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The arbiter FSM walks IDLE -> D_WAIT -> I_WAIT -> DONE.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_MEM_LAT = 2;

  // Instruction register value while nothing has been fetched (pipeline bubble).
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises a data access and then an instruction
// fetch through a fixed-latency memory, holding ready low while either is in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = DEFAULT_MEM_LAT,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned       CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_RET  = CNT_W'(1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_pend_q, i_pend_d;
  logic              is_read_q, is_read_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]       stall_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    i_pend_d  = i_pend_q;
    is_read_d = is_read_q;
    instr_d   = instr_q;
    rd_data_d = rd_data_q;
    ready     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (re || we) begin
          // re and we together is a store; the load half is dropped.
          mem_en    = 1'b1;
          mem_we    = we;
          mem_addr  = d_addr;
          mem_wdata = we ? wrt_data : '0;
          cnt_d     = LAT_LOAD;
          i_pend_d  = i_fetch;
          is_read_d = ~we;
          state_d   = D_WAIT;
        end else if (i_fetch) begin
          mem_en   = 1'b1;
          mem_addr = i_addr;
          cnt_d    = LAT_LOAD;
          state_d  = I_WAIT;
        end else begin
          ready = 1'b1;
        end
      end

      D_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_RET) begin
          if (is_read_q) rd_data_d = mem_rdata;
          // The return cycle frees the port, so the pending fetch issues immediately.
          if (i_pend_q) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
            cnt_d    = LAT_LOAD;
            i_pend_d = 1'b0;
            state_d  = I_WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end

      I_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_RET) begin
          instr_d = mem_rdata;
          state_d = DONE;
        end
      end

      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // While reset is held nothing is issued to memory and the pipeline sees ready.
    if (rst) begin
      ready     = 1'b1;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_pend_q  <= 1'b0;
      is_read_q <= 1'b0;
      instr_q   <= DATA_W'(NOP_INSTR);
      rd_data_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i_pend_q  <= i_pend_d;
      is_read_q <= is_read_d;
      instr_q   <= instr_d;
      rd_data_q <= rd_data_d;
      if (!ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign instr     = instr_q;
  assign rd_data   = rd_data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LAT=2 and a
// behavioural fixed-latency memory that returns 16'hDEAD outside valid cycles.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst;
  logic        i_fetch;
  logic [15:0] i_addr;
  logic        re;
  logic        we;
  logic [15:0] d_addr;
  logic [15:0] wrt_data;
  logic [15:0] instr;
  logic [15:0] rd_data;
  logic        ready;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_fetch   (i_fetch),
    .i_addr    (i_addr),
    .re        (re),
    .we        (we),
    .d_addr    (d_addr),
    .wrt_data  (wrt_data),
    .instr     (instr),
    .rd_data   (rd_data),
    .ready     (ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: read data is valid exactly LAT cycles after the mem_en cycle.
  logic [15:0] mem    [0:255];
  logic [15:0] pipe_d [0:LAT-1];
  logic        pipe_v [0:LAT-1];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_d[0] <= mem[mem_addr[7:0]];
    pipe_v[0] <= mem_en && !mem_we;
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

  task automatic drive_idle();
    i_fetch  = 1'b0;
    re       = 1'b0;
    we       = 1'b0;
    i_addr   = 16'h0000;
    d_addr   = 16'h0000;
    wrt_data = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_fetch = 1'b1; re = 1'b1; i_addr = 16'h0010; d_addr = 16'h0040;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL post_reset_mem_addr: got %h expected 0000", mem_addr); end
  endtask

  task automatic test_idle(input string tag);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b1 || mem_en !== 1'b0) begin
        errors++; $display("FAIL %s_cycle%0d: got ready=%b mem_en=%b expected ready=1 mem_en=0", tag, c, ready, mem_en);
      end
    end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL %s_stall: got %0d expected %0d", tag, stall_cnt, exp_stall); end
  endtask

  task automatic test_fetch_only();
    @(posedge clk); #1;
    i_fetch = 1'b1; i_addr = 16'h0010;
    @(negedge clk); // T0
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_issue: got en=%b addr=%h we=%b expected en=1 addr=0010 we=0", mem_en, mem_addr, mem_we);
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_t0: got %b expected 0", ready); end
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL fetch_wait_t%0d: got ready=%b mem_en=%b expected 0 0", t, ready, mem_en);
      end
    end
    @(negedge clk); // T0+3
    exp_stall += 3;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fetch_ready_t3: got %b expected 1", ready); end
    checks++; if (instr !== 16'hB123) begin errors++; $display("FAIL fetch_instr: got %h expected B123", instr); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL fetch_stall: got %0d expected %0d", stall_cnt, exp_stall); end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // Data access followed by a fetch; covers load+fetch and store+fetch.
  task automatic test_data_fetch(input string tag, input logic is_wr, input logic [15:0] da,
                                 input logic [15:0] wd, input logic [15:0] ia,
                                 input logic [15:0] exp_rd, input logic [15:0] exp_ins);
    @(posedge clk); #1;
    re = ~is_wr; we = is_wr; d_addr = da; wrt_data = wd; i_fetch = 1'b1; i_addr = ia;
    @(negedge clk); // T0
    checks++; if (mem_en !== 1'b1 || mem_addr !== da || mem_we !== is_wr) begin
      errors++; $display("FAIL %s_data_issue: got en=%b addr=%h we=%b expected en=1 addr=%h we=%b", tag, mem_en, mem_addr, mem_we, da, is_wr);
    end
    checks++; if (mem_wdata !== (is_wr ? wd : 16'h0000)) begin
      errors++; $display("FAIL %s_wdata: got %h expected %h", tag, mem_wdata, is_wr ? wd : 16'h0000);
    end
    @(negedge clk); // T0+1
    checks++; if (mem_en !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL %s_t1: got en=%b ready=%b expected 0 0", tag, mem_en, ready);
    end
    @(negedge clk); // T0+2
    checks++; if (mem_en !== 1'b1 || mem_addr !== ia || mem_we !== 1'b0 || mem_wdata !== 16'h0000) begin
      errors++; $display("FAIL %s_fetch_issue: got en=%b addr=%h we=%b wdata=%h expected en=1 addr=%h we=0 wdata=0000", tag, mem_en, mem_addr, mem_we, mem_wdata, ia);
    end
    for (int t = 3; t <= 4; t++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL %s_t%0d: got ready=%b en=%b expected 0 0", tag, t, ready, mem_en);
      end
    end
    @(negedge clk); // T0+5
    exp_stall += 5;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_t5: got %b expected 1", tag, ready); end
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL %s_rd_data: got %h expected %h", tag, rd_data, exp_rd); end
    checks++; if (instr !== exp_ins) begin errors++; $display("FAIL %s_instr: got %h expected %h", tag, instr, exp_ins); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL %s_stall: got %0d expected %0d", tag, stall_cnt, exp_stall); end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // Data access with no fetch pending: ready returns at T0+3.
  task automatic test_data_only(input string tag, input logic r, input logic w,
                                input logic [15:0] da, input logic [15:0] wd,
                                input logic [15:0] exp_rd, input logic [15:0] exp_ins);
    @(posedge clk); #1;
    re = r; we = w; d_addr = da; wrt_data = wd;
    @(negedge clk); // T0
    checks++; if (mem_en !== 1'b1 || mem_we !== w || mem_addr !== da) begin
      errors++; $display("FAIL %s_issue: got en=%b we=%b addr=%h expected en=1 we=%b addr=%h", tag, mem_en, mem_we, mem_addr, w, da);
    end
    @(negedge clk);
    @(negedge clk); // T0+2
    checks++; if (mem_en !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL %s_t2: got en=%b ready=%b expected 0 0", tag, mem_en, ready);
    end
    @(negedge clk); // T0+3
    exp_stall += 3;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_t3: got %b expected 1", tag, ready); end
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL %s_rd_data: got %h expected %h", tag, rd_data, exp_rd); end
    checks++; if (instr !== exp_ins) begin errors++; $display("FAIL %s_instr: got %h expected %h", tag, instr, exp_ins); end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid_fetch();
    @(posedge clk); #1;
    i_fetch = 1'b1; i_addr = 16'h0013;
    @(negedge clk); // T0
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0013) begin
      errors++; $display("FAIL midrst_issue: got en=%b addr=%h expected en=1 addr=0013", mem_en, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    exp_stall = 0;
    @(negedge clk); // T0+2: aborted fetch data is on mem_rdata now
    checks++; if (mem_rdata !== 16'h9999) begin errors++; $display("FAIL midrst_model_rdata: got %h expected 9999", mem_rdata); end
    checks++; if (ready !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL midrst_t2: got ready=%b en=%b expected 1 0", ready, mem_en);
    end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall: got %0d expected 0", stall_cnt); end
    @(negedge clk); // T0+3
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL midrst_instr: got %h expected 0000", instr); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL midrst_rd_data: got %h expected 0000", rd_data); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_t3_ready: got %b expected 1", ready); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'hFFFF;
    for (int i = 0; i < LAT; i++) begin
      pipe_d[i] = 16'h0000;
      pipe_v[i] = 1'b0;
    end
    mem[8'h10] = 16'hB123;
    mem[8'h11] = 16'hA001;
    mem[8'h12] = 16'h7E57;
    mem[8'h13] = 16'h9999;
    mem[8'h40] = 16'h5555;
    drive_idle();
    rst = 1'b1;

    test_reset();
    test_idle("idle_start");
    test_fetch_only();
    test_data_fetch("load_fetch", 1'b0, 16'h0040, 16'h0000, 16'h0011, 16'h5555, 16'hA001);
    test_data_fetch("store_fetch", 1'b1, 16'h0041, 16'h1234, 16'h0012, 16'h5555, 16'h7E57);
    test_data_only("load_back", 1'b1, 1'b0, 16'h0041, 16'h0000, 16'h1234, 16'h7E57);
    test_data_only("re_and_we", 1'b1, 1'b1, 16'h0042, 16'hBEEF, 16'h1234, 16'h7E57);
    test_data_only("load_rw", 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hBEEF, 16'h7E57);
    test_idle("idle_after");
    test_reset_mid_fetch();
    test_fetch_only();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
